// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types for the LC-3b memory-port arbiter: the cache line type, the
// arbiter FSM state encoding and the requester identity used for round-robin.
package mem_port_arbiter_pkg;

  typedef logic [127:0] lc3b_line;

  localparam int LC3B_LINE_BITS = $bits(lc3b_line);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_I = 3'd1,
    SERVE_D = 3'd2,
    RESP_I  = 3'd3,
    RESP_D  = 3'd4
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } arb_src_t;

endpackage

// File: rtl/mem_port_arbiter_line_reg.sv
// line_reg
// Load-enabled line-wide holding register with asynchronous active-low clear.
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   async active-low clear
//   load     in   capture d on the next rising edge
//   d        in   WIDTH-bit data in
//   q        out  WIDTH-bit registered data, held until the next load
module line_reg #(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single physical-memory port between the icache miss path and the
// dcache miss/writeback path. One line transaction at a time, round-robin on ties,
// registered line data and a one-cycle resp back to the winning cache.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   i_read, i_address                  icache fill request (held until i_resp)
//   i_rdata, i_resp                    line and completion pulse to icache
//   d_read, d_write, d_address, d_wdata dcache fill / writeback request
//   d_rdata, d_resp                    line and completion pulse to dcache
//   pmem_read, pmem_write              registered physical-memory strobes
//   pmem_address, pmem_wdata           combinational from the granted side
//   pmem_rdata, pmem_resp              physical-memory read line and done
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; sample requests and grant one side
// SERVE_I | icache read in flight on pmem, wait for pmem_resp
// SERVE_D | dcache read or writeback in flight, wait for pmem_resp
// RESP_I  | one-cycle i_resp pulse, then back to IDLE
// RESP_D  | one-cycle d_resp pulse, then back to IDLE
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = LC3B_LINE_BITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  arb_state_t state;
  arb_src_t   last_grant;
  logic       d_req;
  logic       grant_i;
  logic       grant_d;
  logic       load_i;
  logic       load_d;

  assign d_req = d_read | d_write;

  // Ties go to the side that did not win last; with last_grant reset to ICACHE
  // the dcache takes the first tie after reset.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      if (i_read && d_req) begin
        grant_d = (last_grant == ICACHE);
        grant_i = (last_grant == DCACHE);
      end else begin
        grant_i = i_read;
        grant_d = d_req;
      end
    end
  end

  // Strobes are latched at grant and held until pmem_resp so that a requester
  // dropping mid-service cannot cut the pmem handshake short.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= ICACHE;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state      <= SERVE_I;
            pmem_read  <= 1'b1;
            pmem_write <= 1'b0;
          end else if (grant_d) begin
            state      <= SERVE_D;
            pmem_write <= d_write;
            pmem_read  <= d_read & ~d_write;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            state      <= RESP_I;
            last_grant <= ICACHE;
            pmem_read  <= 1'b0;
            i_resp     <= 1'b1;
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            state      <= RESP_D;
            last_grant <= DCACHE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            d_resp     <= 1'b1;
          end
        end
        RESP_I, RESP_D: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state == SERVE_I) begin
      pmem_address = i_address;
    end else if (state == SERVE_D) begin
      pmem_address = d_address;
      pmem_wdata   = d_wdata;
    end
  end

  // Writebacks leave d_rdata untouched; pmem_read is the latched read-op flag.
  assign load_i = (state == SERVE_I) && pmem_resp;
  assign load_d = (state == SERVE_D) && pmem_resp && pmem_read;

  line_reg #(.WIDTH(LINE_WIDTH)) u_i_line (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_i),
    .d       (pmem_rdata),
    .q       (i_rdata)
  );

  line_reg #(.WIDTH(LINE_WIDTH)) u_d_line (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load_d),
    .d       (pmem_rdata),
    .q       (d_rdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed-vector bench for mem_port_arbiter. Inputs change and outputs are
// sampled 1 ns after the rising edge.
module tb_mem_port_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int vectors     = 0;
  int miscompares = 0;

  localparam logic [127:0] LINE_A5 = {16{8'hA5}};
  localparam logic [127:0] LINE_WB = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] LINE_D1 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] LINE_D2 = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
  localparam logic [127:0] LINE_D3 = 128'h0F0F_0F0F_F0F0_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] LINE_XX = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;

  mem_port_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first strobe cycle; pmem_resp is raised in the lat-th strobe
  // cycle and the task returns in the following (resp) cycle.
  task automatic pmem_complete(input int lat, input logic [127:0] data);
    repeat (lat - 1) tick();
    pmem_resp  = 1'b1;
    pmem_rdata = data;
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = LINE_XX;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " i_resp"},       i_resp,       '0);
    chk({tag, " d_resp"},       d_resp,       '0);
    chk({tag, " pmem_read"},    pmem_read,    '0);
    chk({tag, " pmem_write"},   pmem_write,   '0);
    chk({tag, " pmem_address"}, pmem_address, '0);
    chk({tag, " pmem_wdata"},   pmem_wdata,   '0);
    chk({tag, " i_rdata"},      i_rdata,      '0);
    chk({tag, " d_rdata"},      d_rdata,      '0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    i_read     = 1'b0;
    i_address  = '0;
    d_read     = 1'b0;
    d_write    = 1'b0;
    d_address  = '0;
    d_wdata    = '0;
    pmem_rdata = LINE_XX;
    pmem_resp  = 1'b0;
    #1;
    do_reset();

    // icache fill
    i_read    = 1'b1;
    i_address = 16'h0040;
    #1;
    chk("i_fill no comb strobe", pmem_read, 1'b0);
    tick();
    chk("i_fill pmem_read", pmem_read, 1'b1);
    chk("i_fill pmem_addr", pmem_address, 16'h0040);
    chk("i_fill pmem_write", pmem_write, 1'b0);
    pmem_complete(5, LINE_A5);
    chk("i_fill i_resp", i_resp, 1'b1);
    chk("i_fill i_rdata", i_rdata, LINE_A5);
    chk("i_fill d_resp", d_resp, 1'b0);
    chk("i_fill strobe off", pmem_read, 1'b0);
    i_read = 1'b0;
    tick();
    chk("i_fill resp one cycle", i_resp, 1'b0);
    chk("i_fill rdata held", i_rdata, LINE_A5);
    chk("i_fill d_resp idle", d_resp, 1'b0);

    // dcache writeback
    d_write   = 1'b1;
    d_address = 16'h1230;
    d_wdata   = LINE_WB;
    tick();
    chk("wb pmem_write", pmem_write, 1'b1);
    chk("wb pmem_read", pmem_read, 1'b0);
    chk("wb pmem_wdata", pmem_wdata, LINE_WB);
    chk("wb pmem_addr", pmem_address, 16'h1230);
    pmem_complete(3, LINE_D3);
    chk("wb d_resp", d_resp, 1'b1);
    chk("wb i_resp", i_resp, 1'b0);
    chk("wb d_rdata untouched", d_rdata, '0);
    chk("wb strobe off", pmem_write, 1'b0);
    d_write = 1'b0;
    tick();
    chk("wb resp one cycle", d_resp, 1'b0);

    // tie right after reset: dcache, then icache, then dcache again
    do_reset();
    i_read    = 1'b1;
    i_address = 16'h0100;
    d_read    = 1'b1;
    d_address = 16'h0200;
    tick();
    chk("tie1 addr dcache", pmem_address, 16'h0200);
    chk("tie1 pmem_read", pmem_read, 1'b1);
    pmem_complete(2, LINE_D1);
    chk("tie1 d_resp", d_resp, 1'b1);
    chk("tie1 d_rdata", d_rdata, LINE_D1);
    d_read = 1'b0;
    tick();
    chk("tie1 idle gap strobe", pmem_read, 1'b0);
    tick();
    chk("tie2 icache read", pmem_read, 1'b1);
    chk("tie2 addr icache", pmem_address, 16'h0100);
    pmem_complete(2, LINE_D2);
    chk("tie2 i_resp", i_resp, 1'b1);
    chk("tie2 i_rdata", i_rdata, LINE_D2);
    chk("tie2 d_rdata held", d_rdata, LINE_D1);
    i_read = 1'b0;
    tick();
    i_read = 1'b1;
    d_read = 1'b1;
    tick();
    chk("tie3 addr dcache", pmem_address, 16'h0200);
    pmem_complete(2, LINE_D1);
    chk("tie3 d_resp", d_resp, 1'b1);
    chk("tie3 i_resp", i_resp, 1'b0);
    d_read = 1'b0;
    i_read = 1'b0;
    tick();

    // icache waits behind a long dcache read
    d_read    = 1'b1;
    d_address = 16'h0300;
    tick();
    chk("wait d addr", pmem_address, 16'h0300);
    i_read    = 1'b1;
    i_address = 16'h0440;
    pmem_complete(10, LINE_D3);
    chk("wait d_resp", d_resp, 1'b1);
    chk("wait d_rdata", d_rdata, LINE_D3);
    chk("wait RESP_D no strobe", pmem_read, 1'b0);
    d_read = 1'b0;
    tick();
    chk("wait IDLE no strobe", pmem_read, 1'b0);
    chk("wait IDLE i_resp", i_resp, 1'b0);
    tick();
    chk("wait i granted", pmem_read, 1'b1);
    chk("wait i addr", pmem_address, 16'h0440);
    pmem_complete(2, LINE_A5);
    chk("wait i_resp", i_resp, 1'b1);
    i_read = 1'b0;
    tick();

    // read and write together: write wins for the whole transaction
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 16'h0500;
    d_wdata   = LINE_D2;
    tick();
    for (int k = 0; k < 3; k++) begin
      chk("rw pmem_write", pmem_write, 1'b1);
      chk("rw pmem_read", pmem_read, 1'b0);
      tick();
    end
    pmem_resp  = 1'b1;
    pmem_rdata = LINE_A5;
    #1;
    chk("rw last cycle write", pmem_write, 1'b1);
    tick();
    pmem_resp = 1'b0;
    chk("rw d_resp", d_resp, 1'b1);
    chk("rw d_rdata not loaded", d_rdata, LINE_D3);
    d_read  = 1'b0;
    d_write = 1'b0;
    tick();

    // reset mid SERVE_D
    d_write   = 1'b1;
    d_address = 16'h0600;
    d_wdata   = LINE_WB;
    tick();
    tick();
    tick();
    chk("rst pre write", pmem_write, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst async write drop", pmem_write, 1'b0);
    chk("rst async read drop", pmem_read, 1'b0);
    d_write = 1'b0;
    tick();
    chk("rst no d_resp", d_resp, 1'b0);
    reset_n = 1'b1;
    tick();
    check_all_zero("post rst");
    tick();
    chk("post rst idle", pmem_write, 1'b0);
    chk("post rst d_resp", d_resp, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
